// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the instruction-fetch (IF) port
// and the load/store (LS) port. One access is in flight at a time: IDLE -> ISSUE ->
// WAIT -> DONE. The RAM has a fixed read latency. Every output is registered.
//
// Optional feature macro: MEM_ARB_RR_EN
//   undefined : fixed priority, LS wins a same-cycle tie (IF may starve)
//   defined   : round-robin, a tie goes to the port not granted last
//               (pointer resets to LS, so IF wins the first tie)
//
// Ports
//   i_clk, i_rst          clock (rising edge), async active-low reset
//   i_if_req/i_if_addr    fetch request, held until o_if_ack
//   o_if_ack/o_if_rdata   one-cycle fetch done pulse, registered fetched word
//   i_ls_req/we/addr/wdata load/store request, held until o_ls_ack
//   o_ls_ack/o_ls_rdata   one-cycle access done pulse, registered load data
//   o_mem_en/we/addr/wdata RAM command (en is one cycle per access)
//   i_mem_rdata           RAM read data, valid MEM_LAT cycles after o_mem_en
//   o_busy                high whenever the FSM is not IDLE
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_ack,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  output logic          o_ls_ack,
  output logic [DW-1:0] o_ls_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          win_ls;      // 1 = current access belongs to LS
  logic          grant_ls_c;  // winner if a grant happens this cycle

`ifdef MEM_ARB_RR_EN
  // Remembers which port got the last grant; a tie goes to the other one.
  logic last_ls;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_ls <= 1'b1;
    end else if (state == IDLE && (i_if_req || i_ls_req)) begin
      last_ls <= grant_ls_c;
    end
  end

  assign grant_ls_c = (i_if_req && i_ls_req) ? !last_ls : i_ls_req;
`else
  assign grant_ls_c = i_ls_req;
`endif

  // Access sequencer with registered RAM command, acks and read data.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      win_ls      <= 1'b0;
      o_if_ack    <= 1'b0;
      o_if_rdata  <= '0;
      o_ls_ack    <= 1'b0;
      o_ls_rdata  <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_if_ack <= 1'b0;
      o_ls_ack <= 1'b0;
      o_mem_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_if_req || i_ls_req) begin
            state       <= ISSUE;
            win_ls      <= grant_ls_c;
            o_busy      <= 1'b1;
            o_mem_en    <= 1'b1;
            o_mem_we    <= grant_ls_c && i_ls_we;
            o_mem_addr  <= grant_ls_c ? i_ls_addr : i_if_addr;
            o_mem_wdata <= grant_ls_c ? i_ls_wdata : '0;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= CW'(MEM_LAT);
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          // Last wait cycle: RAM data is valid now, ack goes out next cycle.
          if (cnt == CW'(1)) begin
            state <= DONE;
            if (win_ls) begin
              o_ls_ack <= 1'b1;
              if (!o_mem_we) o_ls_rdata <= i_mem_rdata;
            end else begin
              o_if_ack <= 1'b1;
              if (!o_mem_we) o_if_rdata <= i_mem_rdata;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          o_busy      <= 1'b0;
          o_mem_we    <= 1'b0;
          o_mem_addr  <= '0;
          o_mem_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model of the arbiter (grant rule plus
// fixed latency from grant to ack), a RAM model with read latency, directed cases
// with literal expectations, a MEM_LAT=3 instance, and randomized traffic.
module tb_mem_arbiter;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req, ls_req, ls_we;
  logic [15:0] if_addr, ls_addr, ls_wdata;
  logic        if_ack, ls_ack, mem_en, mem_we, busy;
  logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if3_req;
  logic [15:0] if3_addr;
  logic        if3_ack, ls3_ack, m3_en, m3_we, busy3;
  logic [15:0] if3_rdata, ls3_rdata, m3_addr, m3_wdata, m3_rdata;

  mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_ack(ls_ack), .o_ls_rdata(ls_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT3)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if3_req), .i_if_addr(if3_addr), .o_if_ack(if3_ack), .o_if_rdata(if3_rdata),
    .i_ls_req(1'b0), .i_ls_we(1'b0), .i_ls_addr(16'h0), .i_ls_wdata(16'h0),
    .o_ls_ack(ls3_ack), .o_ls_rdata(ls3_rdata),
    .o_mem_en(m3_en), .o_mem_we(m3_we), .o_mem_addr(m3_addr), .o_mem_wdata(m3_wdata),
    .i_mem_rdata(m3_rdata), .o_busy(busy3)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // RAM with LAT-cycle read pipeline; data off the valid cycle is noise.
  logic [15:0] ram [256];
  logic        pv  [LAT];
  logic [15:0] pd  [LAT];
  logic [15:0] noise;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      for (int i = 0; i < LAT; i++) begin pv[i] <= 1'b0; pd[i] <= 16'h0; end
      noise <= 16'h0;
    end else begin
      pv[0] <= mem_en && !mem_we;
      pd[0] <= ram[mem_addr[7:0]];
      for (int i = 1; i < LAT; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
      if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      noise <= 16'($urandom);
    end
  end
  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : noise;

  // RAM for the MEM_LAT=3 instance: returns ~addr three cycles after en.
  logic [2:0]  v3;
  logic [15:0] d3 [3];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3 <= 3'b0;
      for (int i = 0; i < 3; i++) d3[i] <= 16'h0;
    end else begin
      v3    <= {v3[1:0], m3_en && !m3_we};
      d3[0] <= ~m3_addr;
      d3[1] <= d3[0];
      d3[2] <= d3[1];
    end
  end
  assign m3_rdata = v3[2] ? d3[2] : noise;

  // Transaction model: t = cycles since grant (-1 when idle).
  // mem_en at t==1, ack at t==LAT+2, idle again the cycle after.
  int          t;
  logic        m_ls, m_we;
  logic [15:0] m_addr, m_wdata, e_if_rd, e_ls_rd;
  logic [15:0] exp_mem [256];
`ifdef MEM_ARB_RR_EN
  logic        m_last_ls;
`endif
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t = -1; m_ls = 1'b0; m_we = 1'b0; m_addr = 16'h0; m_wdata = 16'h0;
      e_if_rd = 16'h0; e_ls_rd = 16'h0;
`ifdef MEM_ARB_RR_EN
      m_last_ls = 1'b1;
`endif
      for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    end else if (t == LAT + 2) begin
      t = -1;
    end else if (t >= 0) begin
      t = t + 1;
      if (t == LAT + 2 && !m_we) begin
        if (m_ls) e_ls_rd = exp_mem[m_addr[7:0]];
        else      e_if_rd = exp_mem[m_addr[7:0]];
      end
    end else if (if_req || ls_req) begin
`ifdef MEM_ARB_RR_EN
      m_ls = (if_req && ls_req) ? !m_last_ls : ls_req;
      m_last_ls = m_ls;
`else
      m_ls = ls_req;
`endif
      m_we    = m_ls && ls_we;
      m_addr  = m_ls ? ls_addr : if_addr;
      m_wdata = m_ls ? ls_wdata : 16'h0;
      if (m_we) exp_mem[m_addr[7:0]] = m_wdata;
      t = 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit act_c;
    act_c = (t >= 1);
    chk("mem_en",    {15'h0, mem_en}, {15'h0, t == 1});
    chk("busy",      {15'h0, busy},   {15'h0, act_c});
    chk("mem_we",    {15'h0, mem_we}, {15'h0, act_c && m_we});
    chk("mem_addr",  mem_addr,  act_c ? m_addr  : 16'h0);
    chk("mem_wdata", mem_wdata, act_c ? m_wdata : 16'h0);
    chk("if_ack",    {15'h0, if_ack}, {15'h0, t == LAT + 2 && !m_ls});
    chk("ls_ack",    {15'h0, ls_ack}, {15'h0, t == LAT + 2 && m_ls});
    chk("if_rdata",  if_rdata, e_if_rd);
    chk("ls_rdata",  ls_rdata, e_ls_rd);
    chk("lat3_ls_ack",    {15'h0, ls3_ack}, 16'h0);
    chk("lat3_ls_rdata",  ls3_rdata, 16'h0);
    chk("lat3_mem_we",    {15'h0, m3_we}, 16'h0);
    chk("lat3_mem_wdata", m3_wdata, 16'h0);
  end

  // Requester behaviour shared by all phases.
  logic ifa = 1'b0, lsa = 1'b0, rec = 1'b0;
  int   prob = 0;
  logic ack_log [$];

  task automatic sample_neg();
    @(negedge clk);
    ifa = if_ack;
    lsa = ls_ack;
    if (rec && if_ack) ack_log.push_back(1'b0);
    if (rec && ls_ack) ack_log.push_back(1'b1);
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
    if (ifa) if_req = 1'b0;
    if (lsa) ls_req = 1'b0;
    if (!if_req && $urandom_range(99) < 32'(prob)) begin
      if_req  = 1'b1;
      if_addr = 16'($urandom_range(15));
    end
    if (!ls_req && $urandom_range(99) < 32'(prob)) begin
      ls_req   = 1'b1;
      ls_we    = 1'($urandom_range(1));
      ls_addr  = 16'($urandom_range(15));
      ls_wdata = 16'($urandom);
    end
  endtask

  initial begin
    int n;
    bit found, drop3;
    if_req = 1'b0; if_addr = 16'h0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = 16'h0; ls_wdata = 16'h0; if3_req = 1'b0; if3_addr = 16'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_mem_en", {15'h0, mem_en}, 16'h0);
    chk("rst_if_rdata", if_rdata, 16'h0);
    chk("rst_ls_rdata", ls_rdata, 16'h0);
    step_edge();
    rst = 1'b1;
    step_edge();

    // IF read of 0x0010.
    if_req = 1'b1; if_addr = 16'h0010;
    for (int k = 0; k < 5; k++) begin
      sample_neg();
      if (k == 1) begin
        chk("t2_mem_en_c1", {15'h0, mem_en}, 16'h1);
        chk("t2_addr_c1", mem_addr, 16'h0010);
      end
      if (k == 2) chk("t2_no_ack_c2", {15'h0, if_ack}, 16'h0);
      if (k == 3) begin
        chk("t2_ack_c3", {15'h0, if_ack}, 16'h1);
        chk("t2_rdata_c3", if_rdata, 16'hBEEF);
      end
      if (k == 4) chk("t2_ack_gone_c4", {15'h0, if_ack}, 16'h0);
      step_edge();
    end

    // LS store then back-to-back load of the same word.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 16'h1234;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      sample_neg();
      if (k == 1) begin
        chk("t3_mem_we", {15'h0, mem_we}, 16'h1);
        chk("t3_mem_wdata", mem_wdata, 16'h1234);
      end
      if (ls_ack) begin
        n++;
        if (n == 1) chk("t3_rdata_after_store", ls_rdata, 16'h0);
        if (n == 2) chk("t3_rdata_after_load", ls_rdata, 16'h1234);
      end
      step_edge();
      if (n == 1 && !ls_req) begin ls_req = 1'b1; ls_we = 1'b0; end
    end
    chk("t3_ack_count", 16'(n), 16'd2);

    // Simultaneous IF and LS requests.
    if_req = 1'b1; if_addr = 16'h0010;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0020;
    for (int k = 0; k < 10; k++) begin
      sample_neg();
`ifdef MEM_ARB_RR_EN
      if (k == 3) begin
        chk("t4_first_if_ack", {15'h0, if_ack}, 16'h1);
        chk("t4_first_ls_ack", {15'h0, ls_ack}, 16'h0);
      end
      if (k == LAT + 4) chk("t4_second_addr", mem_addr, 16'h0020);
`else
      if (k == 3) begin
        chk("t4_first_ls_ack", {15'h0, ls_ack}, 16'h1);
        chk("t4_first_if_ack", {15'h0, if_ack}, 16'h0);
      end
      if (k == LAT + 4) chk("t4_second_addr", mem_addr, 16'h0010);
`endif
      if (k == 4) chk("t4_idle_gap", {15'h0, mem_en}, 16'h0);
      if (k == LAT + 4) chk("t4_second_mem_en", {15'h0, mem_en}, 16'h1);
      step_edge();
    end

    // Reset in the middle of WAIT abandons the access.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0005;
    sample_neg();
    step_edge();
    sample_neg();
    chk("t1_mem_en_c1", {15'h0, mem_en}, 16'h1);
    step_edge();
    rst = 1'b0;
    #1;
    chk("t1_mem_en_async", {15'h0, mem_en}, 16'h0);
    chk("t1_busy_async", {15'h0, busy}, 16'h0);
    sample_neg();
    chk("t1_no_ack", {15'h0, ls_ack}, 16'h0);
    step_edge();
    sample_neg();
    step_edge();
    rst = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample_neg();
      if (ls_ack && !found) begin
        found = 1'b1;
        chk("t1_rdata_after_reset", ls_rdata, init_val(5));
      end
      step_edge();
    end
    chk("t1_ack_after_reset", {15'h0, found}, 16'h1);

    // Continuous requests from both ports, starting from a fresh pointer.
    rst = 1'b0;
    sample_neg();
    step_edge();
    rst = 1'b1;
    rec = 1'b1; prob = 100;
    if_req = 1'b1; if_addr = 16'h0003;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0004;
    for (int k = 0; k < 40 && ack_log.size() < 4; k++) begin
      sample_neg();
      step_edge();
    end
    rec = 1'b0; prob = 0;
    if_req = 1'b0; ls_req = 1'b0;
    chk("t5_grant_count", 16'(ack_log.size() >= 4), 16'h1);
    for (int k = 0; k < 4 && k < ack_log.size(); k++) begin
`ifdef MEM_ARB_RR_EN
      chk($sformatf("t5_grant_%0d", k), {15'h0, ack_log[k]}, 16'(k % 2));
`else
      chk($sformatf("t5_grant_%0d", k), {15'h0, ack_log[k]}, 16'h1);
`endif
    end
    for (int k = 0; k < 8; k++) begin sample_neg(); step_edge(); end

    // MEM_LAT=3 instance: ack in c5, exactly one cycle wide.
    if3_req = 1'b1; if3_addr = 16'h0033;
    drop3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample_neg();
      if (k == 1) chk("t6_mem_en_c1", {15'h0, m3_en}, 16'h1);
      if (k == 3) chk("t6_busy_c3", {15'h0, busy3}, 16'h1);
      if (k == 4) chk("t6_no_ack_c4", {15'h0, if3_ack}, 16'h0);
      if (k == 5) begin
        chk("t6_ack_c5", {15'h0, if3_ack}, 16'h1);
        chk("t6_rdata_c5", if3_rdata, 16'hFFCC);
      end
      if (k == 6) chk("t6_ack_gone_c6", {15'h0, if3_ack}, 16'h0);
      if (if3_ack) drop3 = 1'b1;
      step_edge();
      if (drop3) if3_req = 1'b0;
    end

    // Randomized traffic.
    prob = 30;
    for (int k = 0; k < 1500; k++) begin sample_neg(); step_edge(); end
    prob = 0;
    for (int k = 0; k < 20; k++) begin sample_neg(); step_edge(); end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
